// File: rtl/ft245_fifo_drain_ctrl_pkg.sv
// ============================================================================
// Module   : ft245_fifo_drain_ctrl_pkg
// Purpose  : State encoding and timer helpers for the FT245 drain controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ft245_fifo_drain_ctrl_pkg;

  localparam int TIMER_W = 4;

  typedef logic [TIMER_W-1:0] timer_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_LATCH    = 3'd2,
    ST_WAIT_TXE = 3'd3,
    ST_SETUP    = 3'd4,
    ST_STROBE   = 3'd5,
    ST_HOLD     = 3'd6,
    ST_RECOV    = 3'd7
  } state_t;

  // A state lasting N cycles loads N-1 and leaves when the timer reads zero.
  function automatic timer_t timer_load(input int cycles);
    return timer_t'(cycles - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ft245_fifo_drain_ctrl_sync2_bit.sv
// ============================================================================
// Module   : sync2_bit
// Purpose  : Two-flop synchronizer with a parameterised reset value.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync2_bit #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/ft245_fifo_drain_ctrl.sv
// ============================================================================
// Module   : ft245_fifo_drain_ctrl
// Purpose  : Pops bytes from a FIFO and writes them to an FT245 with timed WR.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ft245_fifo_drain_ctrl
  import ft245_fifo_drain_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WR_SETUP   = 1,
  parameter int WR_PULSE   = 3,
  parameter int WR_HOLD    = 1,
  parameter int RECOV      = 4
) (
  input  logic                  rclk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_dat,
  input  logic                  ft_txe_n,
  output logic                  ft_wr,
  output logic [DATA_WIDTH-1:0] ft_d,
  output logic                  ft_d_oe,
  output logic                  busy,
  output logic [15:0]           byte_cnt
);

  state_t                state_q;
  timer_t                timer_q;
  logic                  fifo_rd_q;
  logic                  ft_wr_q;
  logic [DATA_WIDTH-1:0] ft_d_q;
  logic                  ft_d_oe_q;
  logic                  busy_q;
  logic [15:0]           byte_cnt_q;
  logic                  txe_sync;
  logic                  txe_ok;

  sync2_bit #(
    .RST_VAL (1'b1)
  ) u_txe_sync (
    .clk_i (rclk),
    .rst_i (rst),
    .d_i   (ft_txe_n),
    .q_o   (txe_sync)
  );

  assign txe_ok = ~txe_sync;

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      fifo_rd_q  <= 1'b0;
      ft_wr_q    <= 1'b0;
      ft_d_q     <= '0;
      ft_d_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      fifo_rd_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable && !fifo_empty) begin
            state_q   <= ST_FETCH;
            fifo_rd_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_FETCH: state_q <= ST_LATCH;
        ST_LATCH: begin
          ft_d_q    <= fifo_dat;
          ft_d_oe_q <= 1'b1;
          state_q   <= ST_WAIT_TXE;
        end
        // Data is already on the bus here, so the cycle that sees txe_ok
        // doubles as the first setup cycle.
        ST_WAIT_TXE: begin
          if (txe_ok) begin
            if (WR_SETUP > 1) begin
              state_q <= ST_SETUP;
              timer_q <= timer_load(WR_SETUP - 1);
            end else begin
              state_q <= ST_STROBE;
              ft_wr_q <= 1'b1;
              timer_q <= timer_load(WR_PULSE);
            end
          end
        end
        ST_SETUP: begin
          if (timer_q == '0) begin
            state_q <= ST_STROBE;
            ft_wr_q <= 1'b1;
            timer_q <= timer_load(WR_PULSE);
          end else begin
            timer_q <= timer_q - timer_t'(1);
          end
        end
        ST_STROBE: begin
          if (timer_q == '0) begin
            state_q    <= ST_HOLD;
            ft_wr_q    <= 1'b0;
            byte_cnt_q <= byte_cnt_q + 16'd1;
            timer_q    <= timer_load(WR_HOLD);
          end else begin
            timer_q <= timer_q - timer_t'(1);
          end
        end
        ST_HOLD: begin
          if (timer_q == '0) begin
            state_q   <= ST_RECOV;
            ft_d_oe_q <= 1'b0;
            timer_q   <= timer_load(RECOV);
          end else begin
            timer_q <= timer_q - timer_t'(1);
          end
        end
        ST_RECOV: begin
          if (timer_q == '0) begin
            if (enable && !fifo_empty) begin
              state_q   <= ST_FETCH;
              fifo_rd_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_q - timer_t'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd  = fifo_rd_q;
  assign ft_wr    = ft_wr_q;
  assign ft_d     = ft_d_q;
  assign ft_d_oe  = ft_d_oe_q;
  assign busy     = busy_q;
  assign byte_cnt = byte_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ft245_fifo_drain_ctrl.sv
// ============================================================================
// Module   : tb_ft245_fifo_drain_ctrl
// Purpose  : Self-checking bench for ft245_fifo_drain_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ft245_fifo_drain_ctrl;

  localparam int DW         = 8;
  localparam int WR_SETUP   = 1;
  localparam int WR_PULSE   = 3;
  localparam int WR_HOLD    = 1;
  localparam int RECOV      = 4;
  localparam int MIN_PERIOD = 2 + WR_SETUP + WR_PULSE + WR_HOLD + RECOV;

  logic          rclk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [DW-1:0] fifo_dat = '0;
  logic          ft_txe_n = 1'b0;
  logic          ft_wr;
  logic [DW-1:0] ft_d;
  logic          ft_d_oe;
  logic          busy;
  logic [15:0]   byte_cnt;

  ft245_fifo_drain_ctrl #(
    .DATA_WIDTH (DW),
    .WR_SETUP   (WR_SETUP),
    .WR_PULSE   (WR_PULSE),
    .WR_HOLD    (WR_HOLD),
    .RECOV      (RECOV)
  ) dut (
    .rclk       (rclk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_dat   (fifo_dat),
    .ft_txe_n   (ft_txe_n),
    .ft_wr      (ft_wr),
    .ft_d       (ft_d),
    .ft_d_oe    (ft_d_oe),
    .busy       (busy),
    .byte_cnt   (byte_cnt)
  );

  always #5 rclk = ~rclk;

  // FIFO model: data appears on fifo_dat the cycle after the pop.
  logic [DW-1:0] mem [0:255];
  logic [7:0]    wr_ptr = '0;
  logic [7:0]    rd_ptr = '0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge rclk) begin
    if (fifo_rd) begin
      fifo_dat <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + 8'd1;
    end
  end

  int          n_pass = 0;
  int          n_total = 0;
  logic [DW-1:0] exp_q [$];
  int          fall_cyc [$];
  int          cyc = 0;
  int          rd_pulses = 0;
  int          wr_len = 0;
  logic        prev_wr = 1'b0;
  logic [15:0] model_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [DW-1:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 8'd1;
    exp_q.push_back(b);
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n = 0;
    do begin
      @(negedge rclk);
      n++;
    end while ((busy || !fifo_empty) && n < bound);
    chk(tag, {31'd0, busy || !fifo_empty}, 32'd0);
  endtask

  task automatic wait_wr(input logic level, input int bound, input string tag);
    int n = 0;
    while (ft_wr !== level && n < bound) begin
      @(negedge rclk);
      n++;
    end
    chk(tag, {31'd0, ft_wr}, {31'd0, level});
  endtask

  // Protocol monitor: every WR falling edge must carry the next queued byte.
  always @(negedge rclk) begin
    logic [DW-1:0] eb;
    cyc++;
    if (rst) begin
      prev_wr   = 1'b0;
      wr_len    = 0;
      model_cnt = '0;
    end else begin
      if (fifo_rd) begin
        rd_pulses++;
        chk("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
      end
      if (ft_wr) wr_len++;
      if (prev_wr && !ft_wr) begin
        chk("pulse_len", wr_len, WR_PULSE);
        wr_len = 0;
        chk("exp_avail", {31'd0, exp_q.size() > 0}, 32'd1);
        eb = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk("ft_d_at_fall", {24'd0, ft_d}, {24'd0, eb});
        chk("oe_at_fall", {31'd0, ft_d_oe}, 32'd1);
        model_cnt = model_cnt + 16'd1;
        chk("byte_cnt_at_fall", {16'd0, byte_cnt}, {16'd0, model_cnt});
        fall_cyc.push_back(cyc);
      end
      prev_wr = ft_wr;
    end
  end

  initial begin
    logic [DW-1:0] b;
    int            rd0, n, nf;
    logic [15:0]   cnt0;

    // Reset values
    #1 rst = 1'b1;
    #2;
    chk("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
    chk("rst_ft_wr", {31'd0, ft_wr}, 32'd0);
    chk("rst_ft_d", {24'd0, ft_d}, 32'd0);
    chk("rst_oe", {31'd0, ft_d_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_byte_cnt", {16'd0, byte_cnt}, 32'd0);
    repeat (2) @(negedge rclk);
    rst = 1'b0;

    // Empty FIFO with enable held high
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge rclk);
      chk("empty_no_rd", {31'd0, fifo_rd}, 32'd0);
      chk("empty_not_busy", {31'd0, busy}, 32'd0);
    end

    // Two back-to-back bytes
    rd0 = rd_pulses;
    nf  = fall_cyc.size();
    push(8'hA5);
    push(8'h3C);
    wait_idle(100, "two_byte_timeout");
    chk("two_byte_falls", fall_cyc.size() - nf, 2);
    if (fall_cyc.size() >= nf + 2)
      chk("fall_spacing", fall_cyc[nf+1] - fall_cyc[nf], MIN_PERIOD);
    chk("two_byte_rd_pulses", rd_pulses - rd0, 2);
    chk("two_byte_cnt", {16'd0, byte_cnt}, 32'd2);

    // TXE# held off for 50 cycles with a byte latched
    ft_txe_n = 1'b1;
    repeat (3) @(negedge rclk);
    b = DW'($urandom);
    push(b);
    repeat (5) @(negedge rclk);
    for (int i = 0; i < 50; i++) begin
      @(negedge rclk);
      chk("txe_hold_no_wr", {31'd0, ft_wr}, 32'd0);
      chk("txe_hold_data", {24'd0, ft_d}, {24'd0, b});
      chk("txe_hold_oe", {31'd0, ft_d_oe}, 32'd1);
    end
    ft_txe_n = 1'b0;
    for (int i = 1; i <= 2 + WR_SETUP; i++) begin
      @(negedge rclk);
      chk("txe_to_wr_latency", {31'd0, ft_wr}, {31'd0, i == 2 + WR_SETUP});
    end
    wait_idle(100, "txe_byte_timeout");

    // enable dropped before the strobe with five bytes queued
    enable = 1'b0;
    for (int i = 0; i < 5; i++) push(DW'($urandom));
    @(negedge rclk);
    rd0  = rd_pulses;
    cnt0 = model_cnt;
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge rclk);
      n++;
    end while (!fifo_rd && n < 10);
    chk("en_drop_first_rd", {31'd0, fifo_rd}, 32'd1);
    repeat (2) @(negedge rclk);
    enable = 1'b0;
    wait_wr(1'b1, 30, "en_drop_wr_rise");
    wait_wr(1'b0, 30, "en_drop_wr_fall");
    n = 0;
    while (busy && n < 60) begin
      chk("oe_hold_then_recov", {31'd0, ft_d_oe}, {31'd0, n < WR_HOLD});
      @(negedge rclk);
      n++;
    end
    chk("busy_fall_delay", n, WR_HOLD + RECOV);
    repeat (30) @(negedge rclk);
    chk("en_drop_rd_count", rd_pulses - rd0, 1);
    chk("en_drop_byte_cnt", {16'd0, byte_cnt}, {16'd0, cnt0 + 16'd1});
    chk("en_drop_fifo_left", {24'd0, wr_ptr - rd_ptr}, 32'd4);
    enable = 1'b1;
    wait_idle(200, "en_drop_drain_timeout");

    // Random arrivals with random TXE# flow control
    for (int i = 0; i < 150; i++) begin
      @(negedge rclk);
      ft_txe_n = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) push(DW'($urandom));
    end
    ft_txe_n = 1'b0;
    wait_idle(600, "random_timeout");
    chk("random_all_written", exp_q.size(), 0);
    chk("random_byte_cnt", {16'd0, byte_cnt}, {16'd0, model_cnt});

    // byte_cnt wrap
    force dut.byte_cnt_q = 16'hFFFE;
    @(negedge rclk);
    release dut.byte_cnt_q;
    model_cnt = 16'hFFFE;
    push(DW'($urandom));
    push(DW'($urandom));
    wait_idle(100, "wrap_timeout");
    chk("wrap_to_zero", {16'd0, byte_cnt}, 32'd0);

    // Reset during the strobe
    push(DW'($urandom));
    wait_wr(1'b1, 30, "mid_strobe_wr_rise");
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ft_wr", {31'd0, ft_wr}, 32'd0);
    chk("mid_rst_oe", {31'd0, ft_d_oe}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_byte_cnt", {16'd0, byte_cnt}, 32'd0);
    void'(exp_q.pop_front());
    repeat (2) @(negedge rclk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge rclk);
      chk("post_rst_idle", {30'd0, busy, fifo_rd}, 32'd0);
    end
    push(DW'($urandom));
    wait_idle(100, "post_rst_timeout");
    chk("post_rst_byte_cnt", {16'd0, byte_cnt}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
